// File: rtl/star_motor_sequencer.sv
// Shared-supply motor sequencer for the star/grill mechanism: dead-time before
// every energisation, mechanical interlocks, end-position stop and fault latch.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | all drives off, waiting for a legal motion command
// S_DEAD  | drives off, dir preset, dead-time counting down
// S_RUN   | selected motor energised, watching end position and timeout
// S_DONE  | end position reached, waiting for the command to change
// S_FAULT | everything off, fault code held until cleared with cmd==0
module star_motor_sequencer #(
    parameter int DEAD_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 20
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_cmd,
    input  logic [1:0] i_grill_pos,
    input  logic [1:0] i_star_pos,
    input  logic       i_fault_clr,
    output logic       o_grill_en,
    output logic       o_grill_dir,
    output logic       o_star_en,
    output logic       o_star_dir,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_fault,
    output logic [1:0] o_fault_code
);

    typedef enum logic [2:0] {S_IDLE, S_DEAD, S_RUN, S_DONE, S_FAULT} state_t;

    localparam logic [1:0] CODE_NONE    = 2'b00;
    localparam logic [1:0] CODE_ILLEGAL = 2'b01;
    localparam logic [1:0] CODE_ILOCK   = 2'b10;
    localparam logic [1:0] CODE_TIMEOUT = 2'b11;

    state_t             state, nxt_state;
    logic [3:0]         r_cmd, nxt_cmd;
    logic [CNT_W-1:0]   cnt, nxt_cnt;
    logic [1:0]         nxt_code;
    logic               cmd_legal;
    logic               cmd_changed;

    function automatic logic interlock_bad(input logic [3:0] c,
                                           input logic [1:0] gpos,
                                           input logic [1:0] spos);
        logic bad;
        bad = (gpos == 2'b11) || (spos == 2'b11);
        if ((c[1] || c[0]) && (gpos != 2'b01)) bad = 1'b1;
        if ((c[3] || c[2]) && (spos == 2'b10)) bad = 1'b1;
        return bad;
    endfunction

    function automatic logic target_hit(input logic [3:0] c,
                                        input logic [1:0] gpos,
                                        input logic [1:0] spos);
        return (c[3] && gpos == 2'b01) || (c[2] && gpos == 2'b00) ||
               (c[1] && spos == 2'b01) || (c[0] && spos == 2'b00);
    endfunction

    assign cmd_legal   = ((i_cmd & (i_cmd - 4'd1)) == 4'd0);
    assign cmd_changed = (i_cmd != r_cmd);

    always_comb begin
        nxt_state = state;
        nxt_cmd   = r_cmd;
        nxt_cnt   = cnt;
        nxt_code  = o_fault_code;
        case (state)
            S_IDLE: begin
                if (i_cmd == 4'd0) begin
                    nxt_state = S_IDLE;
                end else if (!cmd_legal) begin
                    nxt_state = S_FAULT;
                    nxt_code  = CODE_ILLEGAL;
                end else if (interlock_bad(i_cmd, i_grill_pos, i_star_pos)) begin
                    nxt_state = S_FAULT;
                    nxt_code  = CODE_ILOCK;
                end else if (target_hit(i_cmd, i_grill_pos, i_star_pos)) begin
                    nxt_cmd   = i_cmd;
                    nxt_state = S_DONE;
                end else begin
                    nxt_cmd   = i_cmd;
                    nxt_cnt   = CNT_W'(DEAD_CYCLES);
                    nxt_state = S_DEAD;
                end
            end
            S_DEAD: begin
                if (cmd_changed) begin
                    nxt_state = S_IDLE;
                end else begin
                    nxt_cnt = cnt - 1'b1;
                    // last dead cycle: hand over to RUN with a fresh run count
                    if (cnt == CNT_W'(1)) begin
                        nxt_cnt   = '0;
                        nxt_state = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (!cmd_legal) begin
                    nxt_state = S_FAULT;
                    nxt_code  = CODE_ILLEGAL;
                end else if (cmd_changed) begin
                    nxt_state = S_IDLE;
                end else if (interlock_bad(r_cmd, i_grill_pos, i_star_pos)) begin
                    nxt_state = S_FAULT;
                    nxt_code  = CODE_ILOCK;
                end else if (target_hit(r_cmd, i_grill_pos, i_star_pos)) begin
                    nxt_state = S_DONE;
                end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    nxt_state = S_FAULT;
                    nxt_code  = CODE_TIMEOUT;
                end else begin
                    nxt_cnt = cnt + 1'b1;
                end
            end
            S_DONE: begin
                if (cmd_changed) nxt_state = S_IDLE;
            end
            S_FAULT: begin
                if (i_fault_clr && (i_cmd == 4'd0)) begin
                    nxt_state = S_IDLE;
                    nxt_code  = CODE_NONE;
                end
            end
            default: begin
                nxt_state = S_IDLE;
                nxt_code  = CODE_NONE;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they line up with state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= S_IDLE;
            r_cmd        <= 4'd0;
            cnt          <= '0;
            o_fault_code <= CODE_NONE;
            o_grill_en   <= 1'b0;
            o_grill_dir  <= 1'b0;
            o_star_en    <= 1'b0;
            o_star_dir   <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_fault      <= 1'b0;
        end else begin
            state        <= nxt_state;
            r_cmd        <= nxt_cmd;
            cnt          <= nxt_cnt;
            o_fault_code <= nxt_code;
            o_grill_en   <= (nxt_state == S_RUN) && (nxt_cmd[3] || nxt_cmd[2]);
            o_star_en    <= (nxt_state == S_RUN) && (nxt_cmd[1] || nxt_cmd[0]);
            o_grill_dir  <= ((nxt_state == S_DEAD) || (nxt_state == S_RUN)) && nxt_cmd[3];
            o_star_dir   <= ((nxt_state == S_DEAD) || (nxt_state == S_RUN)) && nxt_cmd[1];
            o_busy       <= (nxt_state == S_DEAD) || (nxt_state == S_RUN);
            o_done       <= (nxt_state == S_DONE);
            o_fault      <= (nxt_state == S_FAULT);
        end
    end

endmodule

// File: tb/tb_star_motor_sequencer.sv
// Directed bench for star_motor_sequencer with DEAD_CYCLES=4, TIMEOUT_CYCLES=20.
// Output vector: {grill_en, grill_dir, star_en, star_dir, busy, done, fault, code[1:0]}.
module tb_star_motor_sequencer;

    logic       i_clk;
    logic       i_rst_n;
    logic [3:0] i_cmd;
    logic [1:0] i_grill_pos;
    logic [1:0] i_star_pos;
    logic       i_fault_clr;
    logic       o_grill_en, o_grill_dir, o_star_en, o_star_dir;
    logic       o_busy, o_done, o_fault;
    logic [1:0] o_fault_code;
    logic [8:0] outs;

    int checks = 0;
    int passes = 0;

    localparam logic [8:0] V_OFF        = 9'b0_0_0_0_0_0_0_00;
    localparam logic [8:0] V_GOPEN_DEAD = 9'b0_1_0_0_1_0_0_00;
    localparam logic [8:0] V_GOPEN_RUN  = 9'b1_1_0_0_1_0_0_00;
    localparam logic [8:0] V_DEAD_DIR0  = 9'b0_0_0_0_1_0_0_00;
    localparam logic [8:0] V_SHIDE_DEAD = 9'b0_0_0_1_1_0_0_00;
    localparam logic [8:0] V_SHIDE_RUN  = 9'b0_0_1_1_1_0_0_00;
    localparam logic [8:0] V_SEXT_RUN   = 9'b0_0_1_0_1_0_0_00;
    localparam logic [8:0] V_DONE       = 9'b0_0_0_0_0_1_0_00;
    localparam logic [8:0] V_F_ILLEGAL  = 9'b0_0_0_0_0_0_1_01;
    localparam logic [8:0] V_F_ILOCK    = 9'b0_0_0_0_0_0_1_10;
    localparam logic [8:0] V_F_TIMEOUT  = 9'b0_0_0_0_0_0_1_11;

    assign outs = {o_grill_en, o_grill_dir, o_star_en, o_star_dir,
                   o_busy, o_done, o_fault, o_fault_code};

    star_motor_sequencer #(
        .DEAD_CYCLES(4),
        .TIMEOUT_CYCLES(20),
        .CNT_W(20)
    ) dut (
        .i_clk(i_clk),
        .i_rst_n(i_rst_n),
        .i_cmd(i_cmd),
        .i_grill_pos(i_grill_pos),
        .i_star_pos(i_star_pos),
        .i_fault_clr(i_fault_clr),
        .o_grill_en(o_grill_en),
        .o_grill_dir(o_grill_dir),
        .o_star_en(o_star_en),
        .o_star_dir(o_star_dir),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_fault(o_fault),
        .o_fault_code(o_fault_code)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_cmd = 4'd0; i_grill_pos = 2'b00; i_star_pos = 2'b00; i_fault_clr = 1'b0;
        repeat (2) tick();
        checks++;
        if (outs !== V_OFF) $display("FAIL reset_hold outs=%b expected=%b", outs, V_OFF);
        else passes++;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();
        checks++;
        if (outs !== V_OFF) $display("FAIL reset_idle outs=%b expected=%b", outs, V_OFF);
        else passes++;
    endtask

    task automatic test_grill_open();
        i_grill_pos = 2'b00; i_star_pos = 2'b00; i_cmd = 4'b1000;
        for (int c = 1; c <= 4; c++) begin
            tick();
            checks++;
            if (outs !== V_GOPEN_DEAD) $display("FAIL gopen_dead c%0d outs=%b expected=%b", c, outs, V_GOPEN_DEAD);
            else passes++;
        end
        for (int c = 5; c <= 12; c++) begin
            tick();
            checks++;
            if (outs !== V_GOPEN_RUN) $display("FAIL gopen_run c%0d outs=%b expected=%b", c, outs, V_GOPEN_RUN);
            else passes++;
            if (c == 5) i_grill_pos = 2'b10;
        end
        i_grill_pos = 2'b01;
        tick();
        checks++;
        if (outs !== V_DONE) $display("FAIL gopen_done outs=%b expected=%b", outs, V_DONE);
        else passes++;
        i_cmd = 4'd0;
        tick();
        checks++;
        if (outs !== V_OFF) $display("FAIL gopen_idle outs=%b expected=%b", outs, V_OFF);
        else passes++;
    endtask

    task automatic test_already_there();
        i_grill_pos = 2'b01; i_star_pos = 2'b00; i_cmd = 4'b1000;
        tick();
        checks++;
        if (outs !== V_DONE) $display("FAIL already_done outs=%b expected=%b", outs, V_DONE);
        else passes++;
        i_cmd = 4'd0;
        tick();
        checks++;
        if (outs !== V_OFF) $display("FAIL already_idle outs=%b expected=%b", outs, V_OFF);
        else passes++;
    endtask

    task automatic test_star_blocked();
        int star_seen = 0;
        i_grill_pos = 2'b00; i_star_pos = 2'b00; i_cmd = 4'b0010;
        tick();
        checks++;
        if (outs !== V_F_ILOCK) $display("FAIL star_blocked outs=%b expected=%b", outs, V_F_ILOCK);
        else passes++;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (o_star_en) star_seen++;
        end
        checks++;
        if (star_seen !== 0) $display("FAIL star_blocked_en cycles=%0d expected=0", star_seen);
        else passes++;
        i_cmd = 4'd0; i_fault_clr = 1'b1;
        tick();
        i_fault_clr = 1'b0;
        checks++;
        if (outs !== V_OFF) $display("FAIL star_blocked_clr outs=%b expected=%b", outs, V_OFF);
        else passes++;
    endtask

    task automatic test_illegal();
        i_grill_pos = 2'b00; i_star_pos = 2'b00; i_cmd = 4'b1100;
        tick();
        checks++;
        if (outs !== V_F_ILLEGAL) $display("FAIL illegal outs=%b expected=%b", outs, V_F_ILLEGAL);
        else passes++;
        i_fault_clr = 1'b1;
        tick();
        checks++;
        if (outs !== V_F_ILLEGAL) $display("FAIL illegal_clr_cmd outs=%b expected=%b", outs, V_F_ILLEGAL);
        else passes++;
        i_cmd = 4'd0;
        tick();
        i_fault_clr = 1'b0;
        checks++;
        if (outs !== V_OFF) $display("FAIL illegal_clr outs=%b expected=%b", outs, V_OFF);
        else passes++;
    endtask

    task automatic test_timeout();
        int en_cycles = 0;
        i_grill_pos = 2'b10; i_star_pos = 2'b00; i_cmd = 4'b0100;
        for (int c = 1; c <= 4; c++) begin
            tick();
            checks++;
            if (outs !== V_DEAD_DIR0) $display("FAIL tmo_dead c%0d outs=%b expected=%b", c, outs, V_DEAD_DIR0);
            else passes++;
        end
        for (int c = 0; c < 40; c++) begin
            tick();
            if (!o_grill_en) break;
            en_cycles++;
        end
        checks++;
        if (en_cycles !== 20) $display("FAIL tmo_en_cycles got=%0d expected=20", en_cycles);
        else passes++;
        checks++;
        if (outs !== V_F_TIMEOUT) $display("FAIL tmo_fault outs=%b expected=%b", outs, V_F_TIMEOUT);
        else passes++;
        i_cmd = 4'd0; i_fault_clr = 1'b1;
        tick();
        i_fault_clr = 1'b0;
        checks++;
        if (outs !== V_OFF) $display("FAIL tmo_clr outs=%b expected=%b", outs, V_OFF);
        else passes++;
    endtask

    task automatic test_reversal();
        i_grill_pos = 2'b01; i_star_pos = 2'b10; i_cmd = 4'b0010;
        for (int c = 1; c <= 4; c++) begin
            tick();
            checks++;
            if (outs !== V_SHIDE_DEAD) $display("FAIL rev_dead1 c%0d outs=%b expected=%b", c, outs, V_SHIDE_DEAD);
            else passes++;
        end
        for (int c = 5; c <= 7; c++) begin
            tick();
            checks++;
            if (outs !== V_SHIDE_RUN) $display("FAIL rev_run1 c%0d outs=%b expected=%b", c, outs, V_SHIDE_RUN);
            else passes++;
        end
        i_cmd = 4'b0001;
        tick();
        checks++;
        if (outs !== V_OFF) $display("FAIL rev_idle outs=%b expected=%b", outs, V_OFF);
        else passes++;
        for (int c = 1; c <= 4; c++) begin
            tick();
            checks++;
            if (outs !== V_DEAD_DIR0) $display("FAIL rev_dead2 c%0d outs=%b expected=%b", c, outs, V_DEAD_DIR0);
            else passes++;
        end
        tick();
        checks++;
        if (outs !== V_SEXT_RUN) $display("FAIL rev_run2 outs=%b expected=%b", outs, V_SEXT_RUN);
        else passes++;
        i_cmd = 4'd0;
        tick();
        checks++;
        if (outs !== V_OFF) $display("FAIL rev_stop outs=%b expected=%b", outs, V_OFF);
        else passes++;
    endtask

    task automatic test_async_reset();
        i_grill_pos = 2'b00; i_star_pos = 2'b00; i_cmd = 4'b1000;
        repeat (5) tick();
        checks++;
        if (outs !== V_GOPEN_RUN) $display("FAIL arst_pre outs=%b expected=%b", outs, V_GOPEN_RUN);
        else passes++;
        #2;
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (outs !== V_OFF) $display("FAIL arst_async outs=%b expected=%b", outs, V_OFF);
        else passes++;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            checks++;
            if (outs !== V_GOPEN_DEAD) $display("FAIL arst_dead c%0d outs=%b expected=%b", c, outs, V_GOPEN_DEAD);
            else passes++;
        end
        tick();
        checks++;
        if (outs !== V_GOPEN_RUN) $display("FAIL arst_run outs=%b expected=%b", outs, V_GOPEN_RUN);
        else passes++;
        i_cmd = 4'd0;
        tick();
    endtask

    initial begin
        test_reset();
        test_grill_open();
        test_already_there();
        test_star_blocked();
        test_illegal();
        test_timeout();
        test_reversal();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/star_motor_sequencer.md
# star_motor_sequencer

Power-stage controller between the star/grill state machine and the single shared motor supply. It takes the 4-bit one-hot motion command and drives at most one actuator (grill or star) at a time. It inserts a dead-time before every energisation, enforces the grill/star mechanical interlocks, and stops the motor at the end position. Runaway, illegal and sensor conditions are latched as faults until cleared.

## Interface
- DEAD_CYCLES, 16, cycles all drives are off before any motor enables (≥1)
- TIMEOUT_CYCLES, 1000000, maximum cycles a motor may run without reaching its end position (≥2)
- CNT_W, 20, counter width; must hold max(DEAD_CYCLES, TIMEOUT_CYCLES)
- i_clk  in  1  system clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_cmd  in  4  motion command: [3] grill open, [2] grill close, [1] star hide, [0] star extend
- i_grill_pos  in  2  grill sensor: 00 closed, 01 open, 10 moving, 11 invalid
- i_star_pos  in  2  star sensor: 00 up, 01 hidden, 10 moving, 11 invalid
- i_fault_clr  in  1  fault clear request
- o_grill_en  out  1  grill motor enable
- o_grill_dir  out  1  grill direction, 1 = open
- o_star_en  out  1  star motor enable
- o_star_dir  out  1  star direction, 1 = hide
- o_busy  out  1  high in DEAD or RUN
- o_done  out  1  high in DONE
- o_fault  out  1  high in FAULT
- o_fault_code  out  2  01 illegal cmd, 10 interlock/sensor, 11 timeout; 00 when no fault

## Operation
- States: IDLE, DEAD, RUN, DONE, FAULT. Outputs are a Moore decode of the registered state plus the latched command r_cmd.
- Legal cmd: zero or exactly one bit set. Targets: grill open→grill 01, grill close→grill 00, star hide→star 01, star extend→star 00.
- Interlock:
  - Star commands require grill_pos==01.
  - Grill commands require star_pos!=10.
  - Either position ==11 is a violation.
- IDLE, evaluated in priority order:
  - cmd==0: stay.
  - Illegal cmd: FAULT, code 01.
  - Interlock violation: FAULT, code 10.
  - Target already reached: latch r_cmd, go to DONE.
  - Otherwise: latch r_cmd, load counter with DEAD_CYCLES, go to DEAD.
- DEAD:
  - Enables low. The dir bit of the selected motor reflects r_cmd.
  - cmd!=r_cmd: IDLE (abort).
  - Counter decrements each cycle; on the cycle it reaches 0, go to RUN and clear the run counter.
- RUN:
  - Selected motor enabled with r_cmd direction; the other motor is off.
  - Per-cycle priority:
    1. Illegal cmd: FAULT 01.
    2. cmd!=r_cmd (including 0): IDLE.
    3. Interlock violation: FAULT 10.
    4. Target reached: DONE.
    5. Run counter == TIMEOUT_CYCLES-1: FAULT 11.
    6. Otherwise: increment the run counter.
- DONE: all off; leave to IDLE when cmd!=r_cmd.
- FAULT:
  - All enables and dirs are 0; o_fault_code holds its value.
  - Go to IDLE only when i_fault_clr==1 and cmd==0 in the same cycle. A new cmd in that cycle is ignored.
- o_grill_en and o_star_en are never high together. Any direction change or motor swap always passes through IDLE→DEAD.

## Timing
- Reset (asynchronous, immediate): state IDLE, r_cmd 0, counters 0, all outputs 0, o_fault_code 00.
- Legal cmd first sampled in IDLE at edge 0:
  - DEAD occupies cycles 1..DEAD_CYCLES.
  - Enable is high from cycle DEAD_CYCLES+1.
- End position sampled at edge n during RUN: enable low from cycle n+1, and o_done is high in that same cycle.
- cmd change sampled at edge n during RUN: enable low in cycle n+1, state IDLE. A new legal cmd still held in IDLE then takes a full dead-time.
- Timeout: enable is high for exactly TIMEOUT_CYCLES cycles, then FAULT 11.
- Reset mid-RUN: enables drop asynchronously. The sequence restarts from IDLE with a full dead-time.

## Test plan
Bench parameters: DEAD_CYCLES=4, TIMEOUT_CYCLES=20.
- Grill open, star_pos=00, grill_pos=00:
  - Apply i_cmd=1000 at edge 0.
  - Expect o_grill_dir=1 during cycles 1–4 with o_grill_en=0, then o_grill_en=1 from cycle 5.
  - Set grill_pos=10, then 01 at edge 12.
  - Expect o_grill_en=0 and o_done=1 at cycle 13.
- Star blocked: grill_pos=00, i_cmd=0010 → FAULT with code 10, o_star_en never asserted.
- Illegal command: i_cmd=1100 in IDLE → o_fault=1, code 01.
  - Clear with i_fault_clr=1 while i_cmd=1100: remain in FAULT.
  - Clear with i_fault_clr=1 and i_cmd=0000: IDLE next cycle.
- Timeout: grill close with grill_pos stuck at 10 → o_grill_en high for exactly 20 cycles, then fault code 11.
- Direction reversal: running star hide (0010), switch to 0001 → star_en low the next cycle, 4 dead cycles, then o_star_en=1 with o_star_dir=0.
- Async reset: assert i_rst_n=0 mid-RUN → all outputs 0 before the next clock edge; after release, a held command re-enters DEAD for 4 cycles.
